// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the serial datapath: the serializer state
// encoding, the default word width, and the depth of the downstream
// serial-in serial-out register that the serializer drives.
// -----------------------------------------------------------------------------
package serial_pkg;

  // PARITY is only reached when PISO_SERIALIZER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 8;

  // Depth of the shift register fed by sout; used for the parent-level
  // latency budget.
  localparam int SISO_DEPTH = 4;

endpackage

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out serializer. Accepts WIDTH-bit words over a
// valid/ready handshake and emits them MSB-first, one bit per clock, with
// back-to-back words streaming with no idle gap.
//
// Optional feature macro: PISO_SERIALIZER_PARITY_EN
//   defined   : each frame is WIDTH data bits followed by one even-parity bit
//   undefined : each frame is exactly WIDTH data bits
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   data_in     in   [WIDTH-1:0] parallel word
//   data_valid  in   upstream word present
//   data_ready  out  block accepts a word this cycle
//   sout        out  serial bit (MSB first)
//   sout_valid  out  sout carries a frame bit
//   busy        out  state is not IDLE
// -----------------------------------------------------------------------------
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  ser_state_t       state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q,    par_d;
`endif

  logic accept;

  // Handshake: a word transfers on a rising edge where data_valid and
  // data_ready are both high. data_ready never depends on data_valid, and
  // upstream must hold data_in stable until the transfer; data_in is ignored
  // at all other times. data_ready is low whenever rst is low, so reset
  // always wins over a simultaneous data_valid.
  always_comb begin
    data_ready = 1'b0;
    case (state_q)
      IDLE:   data_ready = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: data_ready = 1'b1;
`else
      // Ready on the last data bit so the next word follows with no gap.
      SHIFT:  data_ready = (bitcnt_q == '0);
`endif
      default: data_ready = 1'b0;
    endcase
    if (!rst) data_ready = 1'b0;
  end

  assign accept = data_valid && data_ready;

  // Serial outputs are decoded from the state register only.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        sout       = shreg_q[WIDTH-1];
        sout_valid = 1'b1;
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        sout       = par_q;
        sout_valid = 1'b1;
      end
`endif
      default: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
      end
    endcase
  end

  assign busy = sout_valid;

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bitcnt_q != '0) begin
          bitcnt_d = bitcnt_q - 1'b1;
        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // A load overrides the shift/return-to-idle decision above; accept can
    // only be high in IDLE, on the last data bit, or in PARITY.
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = data_in;
      bitcnt_d = CNT_MAX;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d    = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Self-checking bench for piso_serializer (WIDTH=8). The reference model keeps
// a queue of the frame bits still to be emitted: a word is ready to be taken
// when at most one bit (the one on sout now) remains, an accepted word appends
// its bits MSB-first (plus parity when PISO_SERIALIZER_PARITY_EN is defined),
// and each edge retires one bit. Reset empties the queue.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int         n_vec;
  int         n_err;
  logic [15:0] cap;
  int          ncap;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives inputs, checks outputs mid-cycle,
  // then advances the model across the next rising edge.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, input bit chk);
    logic m_ready, m_sout, m_valid;
    rst        = r;
    data_valid = v;
    data_in    = d;
    #4;
    m_valid = (exp_q.size() > 0);
    m_sout  = m_valid ? exp_q[0] : 1'b0;
    m_ready = r && (exp_q.size() <= 1);
    if (chk) begin
      check_eq("data_ready", 16'(data_ready), 16'(m_ready));
      check_eq("sout",       16'(sout),       16'(m_sout));
      check_eq("sout_valid", 16'(sout_valid), 16'(m_valid));
      check_eq("busy",       16'(busy),       16'(m_valid));
    end
    if (sout_valid === 1'b1) begin
      cap = {cap[14:0], sout};
      ncap++;
    end
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (v && m_ready) push_word(d);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, W'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic clear_cap();
    cap  = '0;
    ncap = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    clear_cap();

    // Reset with valid held high and 0xFF presented; first edge unchecked
    // because state is undefined before it.
    cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    idle(2);

    // Single word 0xA5.
    clear_cap();
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    idle(FRAME + 3);
`ifdef PISO_SERIALIZER_PARITY_EN
    check_eq("a5_frame", cap, 16'({8'hA5, 1'b0}));
`else
    check_eq("a5_frame", cap, 16'h00A5);
`endif
    check_eq("a5_len", 16'(ncap), 16'(FRAME));

    // Back-to-back 0xFF then 0x00 with valid held.
    clear_cap();
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b1, 8'h00, 1'b1);
    idle(FRAME + 2);
    check_eq("b2b_len", 16'(ncap), 16'(2 * FRAME));
`ifndef PISO_SERIALIZER_PARITY_EN
    check_eq("b2b_bits", cap, 16'hFF00);
`endif

    // Stall: 0x3C presented from bit 3 of an 0x81 frame.
    clear_cap();
    cycle(1'b1, 1'b1, 8'h81, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < FRAME - 2; i++) cycle(1'b1, 1'b1, 8'h3C, 1'b1);
    idle(FRAME + 2);
    check_eq("stall_len", 16'(ncap), 16'(2 * FRAME));
`ifndef PISO_SERIALIZER_PARITY_EN
    check_eq("stall_bits", cap, 16'h813C);
`endif

    // Mid-frame reset during bit 4 of 0xF0, then a fresh word.
    clear_cap();
    cycle(1'b1, 1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    check_eq("rst_mid_valid", 16'(sout_valid), 16'd0);
    check_eq("rst_mid_sout",  16'(sout),       16'd0);
    idle(FRAME);
    check_eq("rst_mid_len", 16'(ncap), 16'd4);
    clear_cap();
    cycle(1'b1, 1'b1, 8'h6B, 1'b1);
    idle(FRAME + 2);
    check_eq("post_rst_len", 16'(ncap), 16'(FRAME));
`ifndef PISO_SERIALIZER_PARITY_EN
    check_eq("post_rst_bits", cap, 16'h006B);
`endif

`ifdef PISO_SERIALIZER_PARITY_EN
    // Parity frames.
    clear_cap();
    cycle(1'b1, 1'b1, 8'h07, 1'b1);
    idle(FRAME + 2);
    check_eq("par07_frame", cap, 16'({8'h07, 1'b1}));
    check_eq("par07_len", 16'(ncap), 16'd9);
    clear_cap();
    cycle(1'b1, 1'b1, 8'h03, 1'b1);
    idle(FRAME + 2);
    check_eq("par03_frame", cap, 16'({8'h03, 1'b0}));
`endif

    // Random traffic with occasional reset; data_in changes freely.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
            W'($urandom_range(0, 255)), 1'b1);
    end
    idle(FRAME + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
